// File: rtl/car_collision_detector.sv
// Frog/car collision detector.
// Snapshots car and frog positions at each frame start, scans one lane per
// clock, then decides hit / freeze / respawn / lives / game-over.
module car_collision_detector #(
  parameter int unsigned LANE_COUNT  = 4,
  parameter int unsigned LANE_Y0     = 64,
  parameter int unsigned LANE_PITCH  = 32,
  parameter int unsigned CAR_W       = 48,
  parameter int unsigned FROG_W      = 32,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned START_LIVES = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Frame_Start,
  input  logic [LANE_COUNT*10-1:0] i_Car_X,
  input  logic [9:0]               i_Frog_X,
  input  logic [9:0]               i_Frog_Y,
  input  logic                     i_Restart,
  output logic                     o_Hit,
  output logic                     o_Respawn,
  output logic                     o_Frog_Freeze,
  output logic [1:0]               o_Lives,
  output logic                     o_Game_Over
);

  localparam int unsigned LW = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
  localparam int unsigned FW = (HIT_FRAMES > 0) ? $clog2(HIT_FRAMES + 1) : 1;
  localparam int unsigned YW = 16;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANE_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DECIDE,
    ST_HOLD,
    ST_GAME_OVER
  } state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    hit_q, hit_d;
  logic [LANE_COUNT*10-1:0] car_snap_q, car_snap_d;
  logic [9:0]              frog_x_q, frog_x_d;
  logic [9:0]              frog_y_q, frog_y_d;
  logic [FW-1:0]           frames_q, frames_d;
  logic [1:0]              lives_q, lives_d;

  logic [9:0]              car_sel;
  logic [10:0]             frog_l, car_l, frog_r, car_r;
  logic [YW-1:0]           lane_top, lane_bot, frog_y_ext;
  logic                    lane_hit;

  // State and snapshot registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      hit_q      <= 1'b0;
      car_snap_q <= '0;
      frog_x_q   <= '0;
      frog_y_q   <= '0;
      frames_q   <= '0;
      lives_q    <= 2'(START_LIVES);
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      hit_q      <= hit_d;
      car_snap_q <= car_snap_d;
      frog_x_q   <= frog_x_d;
      frog_y_q   <= frog_y_d;
      frames_q   <= frames_d;
      lives_q    <= lives_d;
    end
  end

  // Overlap test for the lane currently indexed; 11-bit sums never wrap
  always_comb begin
    car_sel    = car_snap_q[32'(lane_q)*10 +: 10];
    frog_l     = {1'b0, frog_x_q};
    car_l      = {1'b0, car_sel};
    frog_r     = frog_l + 11'(FROG_W);
    car_r      = car_l + 11'(CAR_W);
    lane_top   = YW'(LANE_Y0) + YW'(lane_q) * YW'(LANE_PITCH);
    lane_bot   = lane_top + YW'(LANE_PITCH);
    frog_y_ext = YW'(frog_y_q);
    lane_hit   = (frog_y_ext >= lane_top) && (frog_y_ext < lane_bot) &&
                 (frog_l < car_r) && (car_l < frog_r);
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    hit_d         = hit_q;
    car_snap_d    = car_snap_q;
    frog_x_d      = frog_x_q;
    frog_y_d      = frog_y_q;
    frames_d      = frames_q;
    lives_d       = lives_q;
    o_Hit         = 1'b0;
    o_Respawn     = 1'b0;
    o_Frog_Freeze = 1'b0;
    o_Game_Over   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_Frame_Start) begin
          car_snap_d = i_Car_X;
          frog_x_d   = i_Frog_X;
          frog_y_d   = i_Frog_Y;
          hit_d      = 1'b0;
          lane_d     = '0;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        hit_d = hit_q | lane_hit;
        if (lane_q == LAST_LANE) begin
          state_d = ST_DECIDE;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end

      ST_DECIDE: begin
        if (hit_q) begin
          o_Hit         = 1'b1;
          o_Frog_Freeze = 1'b1;
          if (lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (lives_q <= 2'd1) begin
            state_d = ST_GAME_OVER;
          end else begin
            frames_d = FW'(HIT_FRAMES);
            state_d  = ST_HOLD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        o_Frog_Freeze = 1'b1;
        if (i_Frame_Start) begin
          if (frames_q <= FW'(1)) begin
            frames_d      = '0;
            o_Respawn     = 1'b1;
            o_Frog_Freeze = 1'b0;
            state_d       = ST_IDLE;
          end else begin
            frames_d = frames_q - FW'(1);
          end
        end
      end

      ST_GAME_OVER: begin
        o_Game_Over   = 1'b1;
        o_Frog_Freeze = 1'b1;
        if (i_Restart) begin
          lives_d = 2'(START_LIVES);
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_Lives = lives_q;

endmodule

// File: tb/tb_car_collision_detector.sv
// Scoreboard bench for car_collision_detector.
module tb_car_collision_detector;

  localparam int LC = 4;
  localparam int Y0 = 64;
  localparam int PITCH = 32;
  localparam int CW = 48;
  localparam int FWID = 32;
  localparam int HF = 3;
  localparam int SL = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fs = 1'b0;
  logic            restart = 1'b0;
  logic [LC*10-1:0] car_x = '0;
  logic [9:0]      fx = '0;
  logic [9:0]      fy = '0;
  logic            hit, resp, frz, over;
  logic [1:0]      lives;

  car_collision_detector #(
    .LANE_COUNT (LC),
    .LANE_Y0    (Y0),
    .LANE_PITCH (PITCH),
    .CAR_W      (CW),
    .FROG_W     (FWID),
    .HIT_FRAMES (HF),
    .START_LIVES(SL)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Frame_Start(fs),
    .i_Car_X      (car_x),
    .i_Frog_X     (fx),
    .i_Frog_Y     (fy),
    .i_Restart    (restart),
    .o_Hit        (hit),
    .o_Respawn    (resp),
    .o_Frog_Freeze(frz),
    .o_Lives      (lives),
    .o_Game_Over  (over)
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_hit;
    int unsigned at;
    int          lives;
  } ev_t;

  ev_t expq[$];
  ev_t e;
  int  checks = 0;
  int  failures = 0;

  // Abstract game model
  int          m_lives = SL;
  bit          m_over = 1'b0;
  int          m_hold = 0;
  int unsigned m_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    int cx;
    int top;
    for (int i = 0; i < LC; i++) begin
      cx  = int'(car_x[i*10 +: 10]);
      top = Y0 + i * PITCH;
      if (int'(fy) >= top && int'(fy) < top + PITCH &&
          int'(fx) < cx + CW && cx < int'(fx) + FWID)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_frame(input int unsigned k);
    if (m_over) return;
    if (k < m_busy) return;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) expq.push_back('{is_hit: 1'b0, at: k, lives: m_lives});
      return;
    end
    m_busy = k + 6;
    if (model_hit()) begin
      expq.push_back('{is_hit: 1'b1, at: k + 5, lives: m_lives});
      m_lives--;
      if (m_lives == 0) m_over = 1'b1;
      else m_hold = HF;
    end
  endtask

  task automatic scramble();
    car_x = {$urandom, $urandom};
    fx    = 10'($urandom);
    fy    = 10'($urandom);
  endtask

  task automatic frame(input int unsigned gap);
    @(posedge clk); #1;
    fs = 1'b1;
    model_frame(cyc);
    @(posedge clk); #1;
    fs = 1'b0;
    scramble();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    @(posedge clk); #1;
    restart = 1'b1;
    if (m_over && cyc >= m_busy) begin
      m_lives = SL;
      m_over  = 1'b0;
    end
    @(posedge clk); #1;
    restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int x, input int y, input int c0, input int c1,
                         input int c2, input int c3);
    fx = 10'(x);
    fy = 10'(y);
    car_x[0 +: 10]  = 10'(c0);
    car_x[10 +: 10] = 10'(c1);
    car_x[20 +: 10] = 10'(c2);
    car_x[30 +: 10] = 10'(c3);
  endtask

  task automatic status(input string tag);
    chk({tag, "_lives"}, lives, m_lives);
    chk({tag, "_over"}, over, m_over);
    chk({tag, "_freeze"}, frz, (m_over || m_hold > 0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_lives", lives, SL);
    chk("rst_freeze", frz, 0);
    chk("rst_over", over, 0);
    chk("rst_hit", hit, 0);
    chk("rst_respawn", resp, 0);
    m_lives = SL;
    m_over  = 1'b0;
    m_hold  = 0;
    m_busy  = 0;
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every hit/respawn pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (hit || resp)) begin
      if (expq.size() == 0) begin
        chk("unexpected_event", {30'd0, hit, resp}, 0);
      end else begin
        e = expq.pop_front();
        chk("event_kind_hit", hit, e.is_hit);
        chk("event_cycle", cyc, e.at);
        if (e.is_hit) chk("hit_lives_before", lives, e.lives);
        else          chk("respawn_freeze", frz, 0);
      end
    end
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lives", lives, SL);
    chk("reset_freeze", frz, 0);
    chk("reset_over", over, 0);
    chk("reset_hit", hit, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frog outside all lanes
    for (int i = 0; i < 5; i++) begin
      scramble();
      fy = '0;
      frame(8);
      chk("no_lane_freeze", frz, 0);
    end
    status("offlane");

    // Basic hit in lane 1
    set_all(100, 96, 600, 80, 600, 600);
    frame(8);
    status("hit1");

    // Freeze held for HF frames, respawn on the last one
    for (int i = 0; i < HF; i++) frame(8);
    status("respawn1");

    // Touching edges do not collide
    set_all(128, 96, 600, 80, 600, 600);
    frame(8);
    status("edge_touch");

    // One pixel of overlap collides
    set_all(128, 96, 600, 81, 600, 600);
    frame(8);
    status("edge_overlap");
    for (int i = 0; i < HF; i++) frame(8);

    // No wrap of 11-bit sums
    set_all(0, 96, 0, 1000, 0, 0);
    frame(8);
    status("no_wrap");

    // Overlapping cars in two lanes, frog on the last row of lane 1
    set_all(100, 127, 600, 90, 90, 600);
    frame(8);
    status("multi_lane");

    // Game over: frame starts ignored
    for (int i = 0; i < 3; i++) begin
      set_all(100, 96, 100, 100, 100, 100);
      frame(8);
    end
    status("game_over");

    do_restart();
    status("restart");

    // Hit, then reset during HOLD
    set_all(100, 96, 600, 80, 600, 600);
    frame(8);
    frame(8);
    status("pre_reset_hold");
    pulse_reset();
    status("post_reset");

    // Randomised play, including frame starts inside the scan window
    for (int n = 0; n < 80; n++) begin
      int unsigned gap;
      if (m_over && ($urandom_range(3, 0) == 0)) do_restart();
      fx = 10'($urandom_range(639, 0));
      fy = 10'($urandom_range(210, 40));
      for (int i = 0; i < LC; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          c = int'(fx) + int'($urandom_range(110, 0)) - 60;
          if (c < 0) c = 0;
          if (c > 1023) c = 1023;
          car_x[i*10 +: 10] = 10'(c);
        end else begin
          car_x[i*10 +: 10] = 10'($urandom_range(1023, 0));
        end
      end
      gap = $urandom_range(10, 1);
      frame(gap);
      if (gap >= 7) status("rand");
    end

    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
